// File: rtl/rx_cdr_ctrl_pkg.sv
// Shared types and default constants for the RX CDR loop controller.
package rx_cdr_ctrl_pkg;

    // DCO code format shared with the RX clock model
    localparam int unsigned DCO_CODE_WIDTH = 14;
    typedef logic [DCO_CODE_WIDTH-1:0] DCO_CODE_FORMAT;

    // Default loop widths and gains
    localparam int unsigned CDR_CODE_WIDTH   = DCO_CODE_WIDTH;
    localparam int unsigned CDR_CODE_INIT    = 8192;
    localparam int unsigned CDR_INT_WIDTH    = 24;
    localparam int unsigned CDR_INT_FRAC     = 8;
    localparam int unsigned CDR_KP_ACQ_SHIFT = 4;
    localparam int unsigned CDR_KI_ACQ_SHIFT = 8;
    localparam int unsigned CDR_KP_TRK_SHIFT = 2;
    localparam int unsigned CDR_KI_TRK_SHIFT = 4;

    // Default acquisition length and lock-evaluation window
    localparam int unsigned CDR_ACQ_UPDATES  = 4096;
    localparam int unsigned CDR_LOCK_WINDOW  = 256;
    localparam int unsigned CDR_LOCK_THRESH  = 16;

    // Signed loop-filter integrator
    typedef logic signed [CDR_INT_WIDTH-1:0] CDR_INT_FORMAT;

    // Loop controller states; encoding 3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } CDR_STATE;

endpackage : rx_cdr_ctrl_pkg

// File: rtl/rx_cdr_lock_det.sv
// Lock detector: accumulates net PD direction over fixed windows of updates
// and flags lock when the absolute imbalance at a window end is small.
module rx_cdr_lock_det
    import rx_cdr_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_WINDOW = CDR_LOCK_WINDOW,
    parameter int unsigned LOCK_THRESH = CDR_LOCK_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_i,
    input  logic signed [1:0] dir_i,
    input  logic              active_i,
    input  logic              clear_i,
    input  logic              hold_i,
    output logic              locked_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_WINDOW);
    localparam int unsigned NET_W = CNT_W + 2;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(LOCK_WINDOW - 1);
    localparam logic signed [NET_W-1:0] THRESH_S = NET_W'(LOCK_THRESH);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [NET_W-1:0] net_q, net_d;
    logic signed [NET_W-1:0] net_nxt, net_abs;
    logic                    locked_q, locked_d;

    // Window bookkeeping and end-of-window lock decision
    always_comb begin
        cnt_d    = cnt_q;
        net_d    = net_q;
        locked_d = locked_q;
        net_nxt  = net_q + NET_W'(dir_i);
        net_abs  = net_nxt[NET_W-1] ? -net_nxt : net_nxt;
        if (clear_i) begin
            cnt_d    = '0;
            net_d    = '0;
            locked_d = 1'b0;
        end else if (hold_i) begin
            locked_d = 1'b0;
        end else if (active_i && upd_i) begin
            if (cnt_q == CNT_LAST) begin
                locked_d = (net_abs <= THRESH_S);
                cnt_d    = '0;
                net_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                net_d = net_nxt;
            end
        end
    end

    // Detector state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            net_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            net_q    <= net_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o = locked_q;

endmodule : rx_cdr_lock_det

// File: rtl/rx_cdr_ctrl.sv
// Bang-bang CDR loop controller: PI loop filter with acquisition and tracking
// gain sets, producing the registered DCO code and a lock flag.
// Optional build macro RX_CDR_OVERRIDE_EN adds a direct code override with
// bumpless resume of the loop.
module rx_cdr_ctrl
    import rx_cdr_ctrl_pkg::*;
#(
    parameter int unsigned CODE_WIDTH   = CDR_CODE_WIDTH,
    parameter int unsigned CODE_INIT    = CDR_CODE_INIT,
    parameter int unsigned INT_WIDTH    = CDR_INT_WIDTH,
    parameter int unsigned INT_FRAC     = CDR_INT_FRAC,
    parameter int unsigned KP_ACQ_SHIFT = CDR_KP_ACQ_SHIFT,
    parameter int unsigned KI_ACQ_SHIFT = CDR_KI_ACQ_SHIFT,
    parameter int unsigned KP_TRK_SHIFT = CDR_KP_TRK_SHIFT,
    parameter int unsigned KI_TRK_SHIFT = CDR_KI_TRK_SHIFT,
    parameter int unsigned ACQ_UPDATES  = CDR_ACQ_UPDATES,
    parameter int unsigned LOCK_WINDOW  = CDR_LOCK_WINDOW,
    parameter int unsigned LOCK_THRESH  = CDR_LOCK_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  upd,
    input  logic                  pd_up,
    input  logic                  pd_dn,
`ifdef RX_CDR_OVERRIDE_EN
    input  logic                  ovr_en,
    input  logic [CODE_WIDTH-1:0] ovr_code,
`endif
    output logic [CODE_WIDTH-1:0] code,
    output logic                  locked,
    output logic [1:0]            state_out
);

    localparam int unsigned IW1    = INT_WIDTH + 1;
    localparam int unsigned PROP_W = CODE_WIDTH + 1;
    localparam int unsigned SUM_W  = CODE_WIDTH + INT_WIDTH - INT_FRAC + 2;
    localparam int unsigned ACQ_W  = $clog2(ACQ_UPDATES);

    localparam logic [ACQ_W-1:0]            ACQ_LAST = ACQ_W'(ACQ_UPDATES - 1);
    localparam logic signed [INT_WIDTH-1:0] INT_MAX  = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic signed [INT_WIDTH-1:0] INT_MIN  = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]     INIT_S   = SUM_W'(CODE_INIT);
    localparam logic signed [SUM_W-1:0]     CODE_MAX = SUM_W'((64'd1 << CODE_WIDTH) - 64'd1);
    localparam logic signed [SUM_W-1:0]     ZERO_S   = '0;
    localparam logic [CODE_WIDTH-1:0]       CODE_RST = CODE_WIDTH'(CODE_INIT);

    // Signed step of +/-2^sh for a PD direction, zero for no decision
    function automatic logic signed [IW1-1:0] scaled_step(input logic signed [1:0] d,
                                                          input int unsigned sh);
        logic signed [IW1-1:0] mag;
        mag = IW1'(1) <<< sh;
        case (d)
            2'sb01:  return mag;
            2'sb11:  return -mag;
            default: return '0;
        endcase
    endfunction

    CDR_STATE                    state_q, state_d;
    logic signed [INT_WIDTH-1:0] integ_q, integ_d;
    logic signed [PROP_W-1:0]    prop_q, prop_d;
    logic [ACQ_W-1:0]            acq_cnt_q, acq_cnt_d;
    logic [CODE_WIDTH-1:0]       code_q, code_d;

    logic signed [1:0]           dir;
    logic                        trk;
    logic signed [IW1-1:0]       integ_sum;
    logic signed [INT_WIDTH-1:0] integ_sat;
    logic signed [PROP_W-1:0]    prop_new;
    logic signed [SUM_W-1:0]     code_sum;
    logic                        det_clear;
    logic                        det_hold;
    logic                        det_locked;

`ifdef RX_CDR_OVERRIDE_EN
    localparam int unsigned PW = SUM_W + INT_FRAC;
    logic                  ovr_q;
    logic signed [PW-1:0]  pre_wide;
    logic signed [INT_WIDTH-1:0] pre_sat;

    // Integrator preload so the loop resumes from the overridden code
    always_comb begin
        pre_wide = (PW'(signed'({1'b0, ovr_code})) - PW'(INIT_S)) <<< INT_FRAC;
        if (pre_wide > PW'(INT_MAX)) begin
            pre_sat = INT_MAX;
        end else if (pre_wide < PW'(INT_MIN)) begin
            pre_sat = INT_MIN;
        end else begin
            pre_sat = pre_wide[INT_WIDTH-1:0];
        end
    end

    // Previous override level for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_en;
        end
    end

    assign det_hold = ovr_en;
`else
    assign det_hold = 1'b0;
`endif

    // PD decision: conflicting or absent votes give no direction
    always_comb begin
        dir = 2'sb00;
        if (pd_up && !pd_dn) begin
            dir = 2'sb01;
        end else if (pd_dn && !pd_up) begin
            dir = 2'sb11;
        end
    end

    // Next-state, loop filter and code computation
    always_comb begin
        state_d   = state_q;
        integ_d   = integ_q;
        prop_d    = prop_q;
        acq_cnt_d = acq_cnt_q;
        trk       = (state_q == TRACK);
        integ_sum = IW1'(integ_q) + scaled_step(dir, trk ? KI_TRK_SHIFT : KI_ACQ_SHIFT);
        prop_new  = PROP_W'(scaled_step(dir, trk ? KP_TRK_SHIFT : KP_ACQ_SHIFT));
        if (integ_sum > IW1'(INT_MAX)) begin
            integ_sat = INT_MAX;
        end else if (integ_sum < IW1'(INT_MIN)) begin
            integ_sat = INT_MIN;
        end else begin
            integ_sat = integ_sum[INT_WIDTH-1:0];
        end

        if (!en) begin
            state_d   = IDLE;
            integ_d   = '0;
            prop_d    = '0;
            acq_cnt_d = '0;
        end
`ifdef RX_CDR_OVERRIDE_EN
        else if (ovr_en) begin
            state_d = state_q;
        end else if (ovr_q) begin
            integ_d = pre_sat;
            prop_d  = '0;
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    state_d   = ACQUIRE;
                    integ_d   = '0;
                    prop_d    = '0;
                    acq_cnt_d = '0;
                end
                ACQUIRE: begin
                    if (upd) begin
                        integ_d = integ_sat;
                        prop_d  = prop_new;
                        if (acq_cnt_q == ACQ_LAST) begin
                            state_d   = TRACK;
                            acq_cnt_d = '0;
                        end else begin
                            acq_cnt_d = acq_cnt_q + ACQ_W'(1);
                        end
                    end
                end
                TRACK: begin
                    if (upd) begin
                        integ_d = integ_sat;
                        prop_d  = prop_new;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    integ_d   = '0;
                    prop_d    = '0;
                    acq_cnt_d = '0;
                end
            endcase
        end

        code_sum = INIT_S + SUM_W'(integ_d >>> INT_FRAC) + SUM_W'(prop_d);
        if (code_sum < ZERO_S) begin
            code_d = '0;
        end else if (code_sum > CODE_MAX) begin
            code_d = '1;
        end else begin
            code_d = code_sum[CODE_WIDTH-1:0];
        end
`ifdef RX_CDR_OVERRIDE_EN
        if (ovr_en) begin
            code_d = ovr_code;
        end
`endif
    end

    // Loop state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            integ_q   <= '0;
            prop_q    <= '0;
            acq_cnt_q <= '0;
            code_q    <= CODE_RST;
        end else begin
            state_q   <= state_d;
            integ_q   <= integ_d;
            prop_q    <= prop_d;
            acq_cnt_q <= acq_cnt_d;
            code_q    <= code_d;
        end
    end

    assign det_clear = !en || (state_q != TRACK);

    rx_cdr_lock_det #(
        .LOCK_WINDOW (LOCK_WINDOW),
        .LOCK_THRESH (LOCK_THRESH)
    ) u_lock_det (
        .clk      (clk),
        .rst      (rst),
        .upd_i    (upd),
        .dir_i    (dir),
        .active_i (trk),
        .clear_i  (det_clear),
        .hold_i   (det_hold),
        .locked_o (det_locked)
    );

    assign code      = code_q;
    assign locked    = det_locked;
    assign state_out = state_q;

endmodule : rx_cdr_ctrl

// File: tb/tb_rx_cdr_ctrl.sv
// Directed bench for rx_cdr_ctrl: default instance for the loop, gain switch,
// lock and disable behaviour; a narrow-integrator instance near the top of
// the code range for integrator saturation and code clamping.
module tb_rx_cdr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, upd = 1'b0, pd_up = 1'b0, pd_dn = 1'b0;
    logic [13:0] code;
    logic        locked;
    logic [1:0]  state_out;

    logic s_en = 1'b0, s_upd = 1'b0, s_up = 1'b0, s_dn = 1'b0;
    logic [13:0] s_code;
    logic        s_locked;
    logic [1:0]  s_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rx_cdr_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .upd       (upd),
        .pd_up     (pd_up),
        .pd_dn     (pd_dn),
`ifdef RX_CDR_OVERRIDE_EN
        .ovr_en    (1'b0),
        .ovr_code  (14'd0),
`endif
        .code      (code),
        .locked    (locked),
        .state_out (state_out)
    );

    rx_cdr_ctrl #(
        .CODE_INIT (16250),
        .INT_WIDTH (16)
    ) u_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (s_en),
        .upd       (s_upd),
        .pd_up     (s_up),
        .pd_dn     (s_dn),
`ifdef RX_CDR_OVERRIDE_EN
        .ovr_en    (1'b0),
        .ovr_code  (14'd0),
`endif
        .code      (s_code),
        .locked    (s_locked),
        .state_out (s_state)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn);
        upd = 1'b1; pd_up = up; pd_dn = dn;
        step();
        upd = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
    endtask

    task automatic s_pulse(input logic up, input logic dn);
        s_upd = 1'b1; s_up = up; s_dn = dn;
        step();
        s_upd = 1'b0; s_up = 1'b0; s_dn = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (3) step();
        chk("rst_code", int'(code), 8192);
        chk("rst_locked", int'(locked), 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_sat_code", int'(s_code), 16250);
        rst = 1'b0;

        // disabled loop ignores PD updates
        repeat (100) pulse(1'b1, 1'b0);
        chk("dis_code", int'(code), 8192);
        chk("dis_locked", int'(locked), 0);
        chk("dis_state", int'(state_out), 0);

        // saturation: 16-bit integrator pins at 32767, code clamps at 16383
        s_en = 1'b1;
        step();
        chk("sat_state", int'(s_state), 1);
        repeat (200) s_pulse(1'b1, 1'b0);
        chk("sat_clamp", int'(s_code), 16383);
        s_pulse(1'b0, 1'b1);
        chk("sat_dn1", int'(s_code), 16360);
        s_pulse(1'b0, 1'b1);
        chk("sat_dn2", int'(s_code), 16359);
        s_en = 1'b0;
        step();
        chk("sat_off", int'(s_code), 16250);

        // acquisition steps
        en = 1'b1;
        step();
        chk("acq_state", int'(state_out), 1);
        chk("acq_code0", int'(code), 8192);
        pulse(1'b1, 1'b0);
        chk("acq_up", int'(code), 8209);
        pulse(1'b0, 1'b1);
        chk("acq_dn", int'(code), 8176);
        repeat (997) pulse(1'b1, 1'b0);
        chk("acq_999", int'(code), 9205);

        // disable on update 1000, same cycle as upd
        en = 1'b0; upd = 1'b1; pd_up = 1'b1;
        step();
        upd = 1'b0; pd_up = 1'b0;
        chk("drop_code", int'(code), 8192);
        chk("drop_state", int'(state_out), 0);

        // re-enable: acquisition counter restarts from zero
        en = 1'b1;
        step();
        chk("reacq_state", int'(state_out), 1);
        repeat (4095) pulse(1'b0, 1'b0);
        chk("acq_4095_state", int'(state_out), 1);
        chk("acq_4095_code", int'(code), 8192);
        pulse(1'b0, 1'b0);
        chk("trk_state", int'(state_out), 2);

        // tracking gains: prop 4, integrator +16 (below one code LSB)
        pulse(1'b1, 1'b0);
        chk("trk_code", int'(code), 8196);
        chk("trk_state2", int'(state_out), 2);

        // window 1: net 0 -> lock at window end
        for (int i = 0; i < 254; i++) begin
            if (i % 2 == 0) pulse(1'b0, 1'b1);
            else            pulse(1'b1, 1'b0);
        end
        chk("w1_pre", int'(locked), 0);
        pulse(1'b0, 1'b1);
        chk("w1_lock", int'(locked), 1);
        chk("w1_code", int'(code), 8188);

        // window 2: net +256 -> lock drops only at window end
        repeat (255) pulse(1'b1, 1'b0);
        chk("w2_mid", int'(locked), 1);
        pulse(1'b1, 1'b0);
        chk("w2_unlock", int'(locked), 0);
        chk("w2_code", int'(code), 8212);

        // window 3: net -16, exactly at threshold -> lock
        repeat (120) pulse(1'b1, 1'b0);
        repeat (136) pulse(1'b0, 1'b1);
        chk("w3_lock", int'(locked), 1);
        chk("w3_code", int'(code), 8203);

        // window 4: net +17, one past threshold -> unlock
        repeat (136) pulse(1'b1, 1'b0);
        repeat (119) pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b0);
        chk("w4_unlock", int'(locked), 0);
        chk("w4_code", int'(code), 8208);

        // disable from tracking
        en = 1'b0;
        step();
        chk("off_code", int'(code), 8192);
        chk("off_state", int'(state_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rx_cdr_ctrl
